// File: rtl/ball_tracker_pkg.sv
// Shared grid geometry, coordinate/velocity types and the prediction FSM
// encoding for the ball detection and tracking blocks.
package ball_tracker_pkg;

    localparam int COLS      = 40;
    localparam int ROWS      = 30;
    localparam int CELL_SIZE = 16;

    typedef logic [5:0]        grid_x_t;
    typedef logic [5:0]        grid_y_t;
    typedef logic signed [6:0] vel_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        PREDICT = 2'd2,
        DONE    = 2'd3
    } fsm_state_e;

    // Magnitude of a per-frame velocity; -64 maps to 64, which still reads
    // correctly as an unsigned 7-bit value.
    function automatic logic [6:0] vel_abs(input vel_t v);
        return v[6] ? 7'(-v) : 7'(v);
    endfunction

endpackage

// File: rtl/ball_tracker_paddle_stepper.sv
// Rate-limited paddle position: one +/-1 step toward the target column per
// divider period, with a single-cycle STEP pulse and its direction.
module ball_tracker_paddle_stepper
    import ball_tracker_pkg::*;
#(
    parameter int STEP_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [5:0] target,
    output logic [5:0] paddle_pos,
    output logic       step,
    output logic       dir
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam grid_x_t          POS_MAX  = grid_x_t'(COLS - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             move_up;

    assign move_up = (target > paddle_pos);

    // Free-running divider; at its terminal count the paddle may take one step.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            div_cnt    <= '0;
            paddle_pos <= grid_x_t'(COLS / 2);
            step       <= 1'b0;
            dir        <= 1'b0;
        end else begin
            step <= 1'b0;
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                if (enable && (paddle_pos != target)) begin
                    step <= 1'b1;
                    dir  <= move_up;
                    if (move_up) begin
                        if (paddle_pos != POS_MAX) paddle_pos <= paddle_pos + 6'd1;
                    end else begin
                        if (paddle_pos != 6'd0) paddle_pos <= paddle_pos - 6'd1;
                    end
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/ball_tracker.sv
// Samples the detected ball once per frame, derives velocity from a two-frame
// history, extrapolates the arrival column at the paddle row (reflecting off
// the side walls) and drives the paddle stepper toward that column.
module ball_tracker
    import ball_tracker_pkg::*;
#(
    parameter int TARGET_ROW  = 29,
    parameter int SAMPLE_LINE = 517,
    parameter int MAX_JUMP    = 4,
    parameter int STEP_DIV    = 1000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic [12:0] VGA_H_CNT,
    input  logic [12:0] VGA_V_CNT,
    input  logic [5:0]  BALL_X,
    input  logic [5:0]  BALL_Y,
    output logic [5:0]  PRED_X,
    output logic        PRED_VALID,
    output logic        BUSY,
    output logic [5:0]  PADDLE_POS,
    output logic        STEP,
    output logic        DIR
);

    localparam logic signed [7:0] X_MAX  = 8'(COLS - 1);
    localparam logic signed [7:0] X_FOLD = 8'(2 * (COLS - 1));

    fsm_state_e        state;
    grid_x_t           cur_x, prev_x, px;
    grid_y_t           cur_y, prev_y;
    logic              hist_valid;
    logic [6:0]        py;
    vel_t              vx, vy;
    grid_x_t           pred_x;
    logic              pred_valid;

    logic              sample_strobe;
    vel_t              dx, dy;
    logic              jump;
    logic signed [7:0] nx, nx_neg, nx_fold;
    logic              hit_low, hit_high;
    grid_x_t           px_next;
    logic [6:0]        py_next;

    assign sample_strobe = (VGA_V_CNT == 13'(SAMPLE_LINE)) && (VGA_H_CNT == 13'd0);

    assign dx   = $signed({1'b0, cur_x}) - $signed({1'b0, prev_x});
    assign dy   = $signed({1'b0, cur_y}) - $signed({1'b0, prev_y});
    assign jump = (vel_abs(dx) > 7'(MAX_JUMP)) || (vel_abs(dy) > 7'(MAX_JUMP));

    // One extrapolation step with a single wall reflection on either side.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        px_next  = '0;
        nx       = $signed({2'b00, px}) + $signed({vx[6], vx});
        nx_neg   = -nx;
        nx_fold  = X_FOLD - nx;
        hit_low  = (nx < 8'sd0);
        hit_high = (nx > X_MAX);
        if (hit_low)       px_next = nx_neg[5:0];
        else if (hit_high) px_next = nx_fold[5:0];
        else               px_next = nx[5:0];
        py_next  = py + $unsigned(vy);
    end

    // Frame history, prediction FSM and the published prediction.
    always_ff @(posedge CLK) begin
        // NOTE: every register, including the history and datapath, is reset so simulation and silicon start identically.
        if (!RST_N) begin
            state      <= IDLE;
            cur_x      <= '0;
            cur_y      <= '0;
            prev_x     <= '0;
            prev_y     <= '0;
            hist_valid <= 1'b0;
            px         <= '0;
            py         <= '0;
            vx         <= '0;
            vy         <= '0;
            pred_x     <= grid_x_t'(COLS / 2);
            pred_valid <= 1'b0;
        end else if (sample_strobe) begin
            // A new frame always wins: any in-flight prediction is dropped.
            cur_x  <= BALL_X;
            cur_y  <= BALL_Y;
            prev_x <= cur_x;
            prev_y <= cur_y;
            state  <= CAPTURE;
        end else begin
            case (state)
                IDLE: ;
                CAPTURE: begin
                    if (!hist_valid) begin
                        pred_x     <= cur_x;
                        pred_valid <= 1'b0;
                        hist_valid <= 1'b1;
                        state      <= IDLE;
                    end else if (jump) begin
                        hist_valid <= 1'b0;
                        pred_x     <= cur_x;
                        pred_valid <= 1'b0;
                        state      <= IDLE;
                    end else if (dy <= 7'sd0) begin
                        pred_x     <= cur_x;
                        pred_valid <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        px    <= cur_x;
                        py    <= {1'b0, cur_y};
                        vx    <= dx;
                        vy    <= dy;
                        state <= PREDICT;
                    end
                end
                PREDICT: begin
                    px <= px_next;
                    py <= py_next;
                    if (hit_low || hit_high) vx <= -vx;
                    if (py_next >= 7'(TARGET_ROW)) state <= DONE;
                end
                DONE: begin
                    pred_x     <= px;
                    pred_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign PRED_X     = pred_x;
    assign PRED_VALID = pred_valid;
    assign BUSY       = (state != IDLE);

    ball_tracker_paddle_stepper #(
        .STEP_DIV (STEP_DIV)
    ) u_stepper (
        .clk        (CLK),
        .rst_n      (RST_N),
        .enable     (ENABLE),
        .target     (pred_x),
        .paddle_pos (PADDLE_POS),
        .step       (STEP),
        .dir        (DIR)
    );

endmodule

// File: tb/tb_ball_tracker.sv
// Self-checking bench for ball_tracker. The reference predicts the arrival
// column in closed form: unfold the walls, advance n frames at once, fold back.
module tb_ball_tracker;

    localparam int STEP_DIV    = 4;
    localparam int SAMPLE_LINE = 517;
    localparam int TGT_ROW     = 29;
    localparam int NCOLS       = 40;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        ENABLE;
    logic [12:0] VGA_H_CNT;
    logic [12:0] VGA_V_CNT;
    logic [5:0]  BALL_X;
    logic [5:0]  BALL_Y;
    logic [5:0]  PRED_X;
    logic        PRED_VALID;
    logic        BUSY;
    logic [5:0]  PADDLE_POS;
    logic        STEP;
    logic        DIR;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_cur_x, m_cur_y, m_prev_x, m_prev_y;
    bit m_hist;
    int exp_pred;
    bit exp_valid;
    int exp_paddle;

    ball_tracker #(
        .TARGET_ROW  (TGT_ROW),
        .SAMPLE_LINE (SAMPLE_LINE),
        .MAX_JUMP    (4),
        .STEP_DIV    (STEP_DIV)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .ENABLE     (ENABLE),
        .VGA_H_CNT  (VGA_H_CNT),
        .VGA_V_CNT  (VGA_V_CNT),
        .BALL_X     (BALL_X),
        .BALL_Y     (BALL_Y),
        .PRED_X     (PRED_X),
        .PRED_VALID (PRED_VALID),
        .BUSY       (BUSY),
        .PADDLE_POS (PADDLE_POS),
        .STEP       (STEP),
        .DIR        (DIR)
    );

    always #5 CLK = ~CLK;

    task automatic model_strobe(input int x, input int y);
        m_prev_x = m_cur_x;
        m_prev_y = m_cur_y;
        m_cur_x  = x;
        m_cur_y  = y;
    endtask

    // Decide the outcome of a completed capture from the frame history.
    task automatic model_resolve();
        int dx, dy, n, xu, m;
        dx = m_cur_x - m_prev_x;
        dy = m_cur_y - m_prev_y;
        if (!m_hist) begin
            exp_pred = m_cur_x; exp_valid = 0; m_hist = 1;
        end else if ((dx < 0 ? -dx : dx) > 4 || (dy < 0 ? -dy : dy) > 4) begin
            exp_pred = m_cur_x; exp_valid = 0; m_hist = 0;
        end else if (dy <= 0) begin
            exp_pred = m_cur_x; exp_valid = 0;
        end else begin
            n = (TGT_ROW - m_cur_y + dy - 1) / dy;
            if (n < 1) n = 1;
            xu = m_cur_x + n * dx;
            m  = ((xu % (2 * (NCOLS - 1))) + 2 * (NCOLS - 1)) % (2 * (NCOLS - 1));
            if (m > NCOLS - 1) m = 2 * (NCOLS - 1) - m;
            exp_pred = m; exp_valid = 1;
        end
    endtask

    // Present one strobe cycle; returns at the following falling edge.
    task automatic pulse_strobe(input int x, input int y);
        @(negedge CLK);
        VGA_V_CNT = 13'(SAMPLE_LINE);
        VGA_H_CNT = 13'd0;
        BALL_X    = 6'(x);
        BALL_Y    = 6'(y);
        @(negedge CLK);
        VGA_H_CNT = 13'd1;
        model_strobe(x, y);
    endtask

    task automatic send_frame(input string name, input int x, input int y);
        bit idle;
        pulse_strobe(x, y);
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_strobe: got %0b expected 1", name, BUSY);
        end
        idle = 0;
        for (int i = 0; i < 64 && !idle; i++) begin
            if (BUSY === 1'b0) idle = 1;
            else @(negedge CLK);
        end
        model_resolve();
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL %s busy_timeout: BUSY still high after 64 cycles", name);
        end else if (PRED_X !== 6'(exp_pred) || PRED_VALID !== exp_valid) begin
            errors++;
            $display("FAIL %s frame(%0d,%0d): got PRED_X=%0d PRED_VALID=%0b expected PRED_X=%0d PRED_VALID=%0b",
                     name, x, y, PRED_X, PRED_VALID, exp_pred, exp_valid);
        end
    endtask

    // Enable the paddle and follow it to the expected target, step by step.
    task automatic settle_paddle(input string name);
        int target, last;
        bit reached, exp_dir;
        target  = exp_pred;
        last    = -1;
        reached = (exp_paddle == target);
        ENABLE  = 1'b1;
        for (int cyc = 0; cyc < STEP_DIV * 50 && !reached; cyc++) begin
            @(negedge CLK);
            if (STEP === 1'b1) begin
                exp_dir = (target > exp_paddle);
                checks++;
                if (DIR !== exp_dir) begin
                    errors++;
                    $display("FAIL %s dir: got %0b expected %0b", name, DIR, exp_dir);
                end
                exp_paddle += exp_dir ? 1 : -1;
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != STEP_DIV) begin
                        errors++;
                        $display("FAIL %s step_gap: got %0d expected %0d", name, cyc - last, STEP_DIV);
                    end
                end
                last = cyc;
                if (exp_paddle == target) reached = 1;
            end
            checks++;
            if (PADDLE_POS !== 6'(exp_paddle)) begin
                errors++;
                $display("FAIL %s paddle_pos: got %0d expected %0d", name, PADDLE_POS, exp_paddle);
            end
        end
        if (!reached) begin
            checks++;
            errors++;
            $display("FAIL %s paddle_timeout: got %0d expected %0d", name, PADDLE_POS, target);
        end
        repeat (3 * STEP_DIV) begin
            @(negedge CLK);
            checks++;
            if (STEP !== 1'b0 || PADDLE_POS !== 6'(exp_paddle)) begin
                errors++;
                $display("FAIL %s paddle_rest: got STEP=%0b POS=%0d expected STEP=0 POS=%0d",
                         name, STEP, PADDLE_POS, exp_paddle);
            end
        end
        ENABLE = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; ENABLE = 1'b0;
        VGA_V_CNT = 13'd0; VGA_H_CNT = 13'd0; BALL_X = '0; BALL_Y = '0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        m_cur_x = 0; m_cur_y = 0; m_prev_x = 0; m_prev_y = 0; m_hist = 0;
        exp_pred = 20; exp_valid = 0; exp_paddle = 20;
        checks++;
        if (PADDLE_POS !== 6'd20 || PRED_X !== 6'd20 || PRED_VALID !== 1'b0 ||
            STEP !== 1'b0 || DIR !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got POS=%0d PRED=%0d VALID=%0b STEP=%0b DIR=%0b BUSY=%0b expected 20 20 0 0 0 0",
                     PADDLE_POS, PRED_X, PRED_VALID, STEP, DIR, BUSY);
        end
        // H==0 on a non-sample line must not strobe; paddle already on target.
        ENABLE = 1'b1;
        repeat (12) begin
            @(negedge CLK);
            checks++;
            if (STEP !== 1'b0 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL reset_quiet: got STEP=%0b BUSY=%0b expected 0 0", STEP, BUSY);
            end
        end
        ENABLE = 1'b0;
    endtask

    task automatic test_straight_drop();
        send_frame("straight", 10, 20);
        send_frame("straight", 12, 22);
    endtask

    task automatic test_paddle_walk();
        send_frame("walk", 26, 20);
        send_frame("walk", 26, 20);
        send_frame("walk", 24, 22);
        settle_paddle("walk");
    endtask

    task automatic test_wall_bounce();
        send_frame("bounce", 37, 20);
        send_frame("bounce", 37, 20);
        send_frame("bounce", 39, 22);
    endtask

    task automatic test_reacquire();
        send_frame("reacq", 5, 10);
        send_frame("reacq", 5, 10);
        send_frame("reacq", 15, 12);
        send_frame("reacq", 16, 13);
    endtask

    task automatic test_moving_away();
        send_frame("away", 8, 20);
        send_frame("away", 8, 20);
        send_frame("away", 9, 18);
        ENABLE = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            checks++;
            if (STEP !== 1'b0 || PADDLE_POS !== 6'(exp_paddle)) begin
                errors++;
                $display("FAIL away_disabled: got STEP=%0b POS=%0d expected STEP=0 POS=%0d",
                         STEP, PADDLE_POS, exp_paddle);
            end
        end
    endtask

    task automatic test_abort();
        int old_pred;
        bit old_valid;
        send_frame("abort", 10, 5);
        send_frame("abort", 10, 5);
        old_pred  = exp_pred;
        old_valid = exp_valid;
        pulse_strobe(12, 7);
        repeat (2) begin
            @(negedge CLK);
            checks++;
            if (BUSY !== 1'b1 || PRED_X !== 6'(old_pred) || PRED_VALID !== old_valid) begin
                errors++;
                $display("FAIL abort_inflight: got BUSY=%0b PRED=%0d VALID=%0b expected 1 %0d %0b",
                         BUSY, PRED_X, PRED_VALID, old_pred, old_valid);
            end
        end
        send_frame("abort", 13, 9);
    endtask

    task automatic test_random();
        int x, y, r;
        x = 20; y = 5;
        for (int i = 0; i < 24; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                x = int'($urandom_range(0, 39));
                y = int'($urandom_range(0, 29));
            end else begin
                x += int'($urandom_range(0, 8)) - 4;
                if (x < 0) x = 0;
                if (x > 39) x = 39;
                if (r < 3) y -= int'($urandom_range(0, 4));
                else       y += int'($urandom_range(1, 4));
                if (y < 0 || y > 29) y = int'($urandom_range(0, 10));
            end
            send_frame("random", x, y);
            if (i % 8 == 7) settle_paddle("random");
        end
    endtask

    initial begin
        test_reset();
        test_straight_drop();
        test_paddle_walk();
        test_wall_bounce();
        test_reacquire();
        test_moving_away();
        test_abort();
        settle_paddle("abort");
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
